// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative integer divider.
// Holds the FSM states, step counts, special-case operands and the word-result fixup.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam int STEPS_64 = 64;
  localparam int STEPS_32 = 32;

  localparam logic [63:0] OVF_DIVIDEND_64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] OVF_DIVIDEND_32 = 32'h8000_0000;
  localparam logic [63:0] ALL_ONES        = 64'hFFFF_FFFF_FFFF_FFFF;

  // W-variant results are always the sign-extension of the low word.
  function automatic logic [63:0] word_fix(input logic [63:0] v, input logic word);
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor if it fits.
module div_step (
  input  logic [63:0] rem,
  input  logic [63:0] quo,
  input  logic [63:0] divisor,
  output logic [63:0] rem_next,
  output logic [63:0] quo_next
);

  logic [64:0] shifted;
  logic [64:0] diff;

  // rem < divisor always holds, so the shifted value needs 65 bits and bit 64 of diff is the borrow.
  always_comb begin
    shifted = {rem, quo[63]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[64]) begin
      rem_next = diff[63:0];
      quo_next = {quo[62:0], 1'b1};
    end else begin
      rem_next = shifted[63:0];
      quo_next = {quo[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative DIV/DIVU/REM/REMU (and W variants) unit for the ex stage.
// Valid/ready contract: stall_o holds the requester from accept until the result; valid_o pulses once with result_o.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic        word_i,
  input  logic [63:0] operand1_i,
  input  logic [63:0] operand2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [63:0] result_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] rem_q, quo_q, div_q, result_q;
  logic        rem_sel_q, word_q, neg_quo_q, neg_rem_q;

  logic [63:0] a_ext, b_ext, mag_a, mag_b;
  logic        sign_a, sign_b, div_zero, overflow, special, accept;
  logic [63:0] special_res, quo_fix, rem_fix, final_res;
  logic [63:0] step_rem, step_quo;

  always_comb begin
    a_ext    = word_i ? (signed_i ? {{32{operand1_i[31]}}, operand1_i[31:0]}
                                  : {32'd0, operand1_i[31:0]}) : operand1_i;
    b_ext    = word_i ? (signed_i ? {{32{operand2_i[31]}}, operand2_i[31:0]}
                                  : {32'd0, operand2_i[31:0]}) : operand2_i;
    sign_a   = signed_i & a_ext[63];
    sign_b   = signed_i & b_ext[63];
    mag_a    = sign_a ? 64'd0 - a_ext : a_ext;
    mag_b    = sign_b ? 64'd0 - b_ext : b_ext;
    div_zero = (b_ext == 64'd0);
    overflow = signed_i & (word_i ? (operand1_i[31:0] == OVF_DIVIDEND_32 &&
                                     operand2_i[31:0] == ALL_ONES[31:0])
                                  : (operand1_i == OVF_DIVIDEND_64 && operand2_i == ALL_ONES));
    special  = div_zero | overflow;
    accept   = (state_q == IDLE) && start_i && !flush_i;
    // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (div_zero) special_res = rem_i ? a_ext : ALL_ONES;
    else          special_res = rem_i ? 64'd0 : a_ext;
    special_res = word_fix(special_res, word_i);
  end

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    quo_fix   = neg_quo_q ? 64'd0 - quo_q : quo_q;
    rem_fix   = neg_rem_q ? 64'd0 - rem_q : rem_q;
    final_res = word_fix(rem_sel_q ? rem_fix : quo_fix, word_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == 6'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign stall_o  = accept || (state_q == CALC) || (state_q == FIX);
  assign valid_o  = (state_q == DONE) && !flush_i;
  assign result_o = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 64'd0;
      quo_q     <= 64'd0;
      div_q     <= 64'd0;
      result_q  <= 64'd0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Word dividends sit in the top half so 32 steps consume exactly their bits.
        quo_q     <= word_i ? (mag_a << 32) : mag_a;
        rem_q     <= 64'd0;
        div_q     <= mag_b;
        cnt_q     <= word_i ? 6'(STEPS_32 - 1) : 6'(STEPS_64 - 1);
        rem_sel_q <= rem_i;
        word_q    <= word_i;
        neg_quo_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        if (special) result_q <= special_res;
      end else if (state_q == CALC) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
      end else if (state_q == FIX && !flush_i) begin
        result_q <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: arithmetic model from the divide rules, a per-cycle compare
// process for valid_o/stall_o/result_o, and literal expectations pinning the model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, signed_i, rem_i, word_i, flush_i;
  logic [63:0] operand1_i, operand2_i;
  logic        stall_o, valid_o;
  logic [63:0] result_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] exp_q[$];
  logic [63:0] lit_q[$];
  int          due_q[$];
  int          acc_q[$];
  int          lat_q[$];
  logic [63:0] last_res = 64'd0;

  div_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .rem_i      (rem_i),
    .word_i     (word_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: architectural divide semantics with plain arithmetic.
  function automatic logic [63:0] ext_op(input bit s, input bit w, input logic [63:0] v);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
  endfunction

  function automatic bit is_special(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ax, bx;
    ax = ext_op(s, w, a);
    bx = ext_op(s, w, b);
    return (bx == 64'd0) || (s && bx == '1 &&
           (w ? ax == 64'hFFFF_FFFF_8000_0000 : ax == 64'h8000_0000_0000_0000));
  endfunction

  function automatic logic [63:0] model_res(input bit s, input bit r, input bit w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ax, bx, q, rm;
    logic signed [63:0] sa, sb;
    ax = ext_op(s, w, a);
    bx = ext_op(s, w, b);
    sa = ax;
    sb = bx;
    if (bx == 64'd0) begin
      q = '1; rm = ax;
    end else if (is_special(s, w, a, b)) begin
      q = ax; rm = 64'd0;
    end else if (s) begin
      q = sa / sb; rm = sa % sb;
    end else begin
      q = ax / bx; rm = ax % bx;
    end
    q = r ? rm : q;
    return w ? {{32{q[31]}}, q[31:0]} : q;
  endfunction

  function automatic int model_lat(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
    if (is_special(s, w, a, b)) return 1;
    return w ? 34 : 66;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Scoreboard / compare process
  always @(negedge clk) begin
    bit exp_v, idle_m, stall_e;
    if (!rst_n) begin
      chk("reset_valid", {63'd0, valid_o}, 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_stall", {63'd0, stall_o}, {63'd0, start_i && !flush_i});
      exp_q.delete(); lit_q.delete(); due_q.delete(); acc_q.delete(); lat_q.delete();
      last_res = 64'd0;
    end else begin
      exp_v   = exp_q.size() > 0 && cyc == due_q[0] && !flush_i;
      idle_m  = exp_q.size() == 0 || cyc == acc_q[0];
      stall_e = (exp_q.size() > 0 && cyc > acc_q[0] && cyc < due_q[0]) ||
                (idle_m && start_i && !flush_i);
      chk("valid", {63'd0, valid_o}, {63'd0, exp_v});
      chk("stall", {63'd0, stall_o}, {63'd0, stall_e});
      if (exp_v) begin
        chk("result", result_o, exp_q[0]);
        chk("model_vs_literal", exp_q[0], lit_q[0]);
        chk("latency_vs_literal", 64'(due_q[0] - acc_q[0]), 64'(lat_q[0]));
        last_res = exp_q[0];
        void'(exp_q.pop_front()); void'(lit_q.pop_front()); void'(due_q.pop_front());
        void'(acc_q.pop_front()); void'(lat_q.pop_front());
      end else begin
        chk("result_hold", result_o, last_res);
        if (exp_q.size() > 0 && cyc >= due_q[0] && !flush_i) begin
          checks++; failures++;
          $display("FAIL timeout cyc=%0d no valid_o by required cycle %0d", cyc, due_q[0]);
          void'(exp_q.pop_front()); void'(lit_q.pop_front()); void'(due_q.pop_front());
          void'(acc_q.pop_front()); void'(lat_q.pop_front());
        end
      end
      if (flush_i) begin
        exp_q.delete(); lit_q.delete(); due_q.delete(); acc_q.delete(); lat_q.delete();
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit s, input bit r, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] lit, input int lat,
                        input bit wait_done);
    start_i = 1'b1; signed_i = s; rem_i = r; word_i = w;
    operand1_i = a; operand2_i = b;
    if (exp_q.size() == 0 && !flush_i && rst_n) begin
      exp_q.push_back(model_res(s, r, w, a, b));
      lit_q.push_back(lit);
      due_q.push_back(cyc + model_lat(s, w, a, b));
      acc_q.push_back(cyc);
      lat_q.push_back(lat);
    end
    tick();
    start_i = 1'b0;
    operand1_i = $urandom_range(0, 255);
    operand2_i = $urandom_range(0, 255);
    if (wait_done) begin
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0; word_i = 1'b0;
    flush_i = 1'b0; operand1_i = 64'd0; operand2_i = 64'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // DIVU 100/7 with a stray start mid-operation that must be ignored
    run_op(0, 0, 0, 64'd100, 64'd7, 64'd14, 66, 0);
    repeat (4) tick();
    run_op(0, 1, 0, 64'd999, 64'd3, 64'd0, 66, 1);
    run_op(0, 1, 0, 64'd100, 64'd7, 64'd2, 66, 1);
    run_op(1, 0, 0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, 1);
    run_op(1, 1, 0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1);
    run_op(1, 1, 0, 64'd100, -64'sd7, 64'd2, 66, 1);
    run_op(1, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    run_op(1, 1, 0, 64'd5, 64'd0, 64'd5, 1, 1);
    run_op(1, 0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1);
    run_op(0, 1, 1, 64'hFFFF_FFFF, 64'd16, 64'h0000_0000_0000_000F, 34, 1);
    run_op(1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1);
    run_op(1, 1, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1);
    run_op(1, 0, 1, 64'h1234_5678_0000_0007, 64'hABCD_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1);
    run_op(1, 1, 1, 64'h1234_5678_0000_0007, 64'hABCD_0000_FFFF_FFFE, 64'd1, 34, 1);
    run_op(0, 0, 1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1);
    run_op(0, 0, 0, '1, 64'd3, 64'h5555_5555_5555_5555, 66, 1);
    run_op(0, 1, 1, 64'h1_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, 1);

    // Start together with flush in IDLE: flush wins, nothing accepted
    flush_i = 1'b1;
    run_op(0, 0, 0, 64'd50, 64'd5, 64'd10, 66, 0);
    flush_i = 1'b0;
    repeat (3) tick();

    // Flush at T+20 of a 64-bit divide, new start at T+21
    run_op(0, 0, 0, 64'd1000, 64'd3, 64'd333, 66, 0);
    repeat (19) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    run_op(0, 1, 0, 64'd1000, 64'd3, 64'd1, 66, 1);

    // Reset at T+10 of a 64-bit divide; the aborted op must never complete
    run_op(1, 0, 0, 64'd77, 64'd11, 64'd7, 66, 0);
    repeat (9) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    run_op(1, 0, 1, 64'hFFFF_FFF0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 34, 1);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
